// File: rtl/line_steer_ctrl.sv
// Purpose: line-following steering controller (PD law, track/search/stop FSM) driving two PWM motor channels.
// Latency: inputs registered once, consumed at the once-per-period tick; new duty applies 1 cycle after the tick (<= 2^PWM_BITS+1 cycles).
// Backpressure: none; inputs are sampled every cycle and the PWM outputs free-run regardless of downstream state.
module line_steer_ctrl #(
    parameter int IMG_W       = 640,
    parameter int PWM_BITS    = 8,
    parameter int KP_SHIFT    = 2,
    parameter int KD_SHIFT    = 3,
    parameter int BASE_DUTY   = 128,
    parameter int SEARCH_DUTY = 64,
    parameter int LOST_LIMIT  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [10:0]         centroid_x,
    input  logic                line_valid,
    input  logic                line_lost,
    output logic                pwm_left,
    output logic                pwm_right,
    output logic [PWM_BITS-1:0] duty_left,
    output logic [PWM_BITS-1:0] duty_right,
    output logic [1:0]          state,
    output logic                cmd_valid
);

    localparam logic [10:0]          X_MAX    = 11'(IMG_W - 1);
    localparam logic signed [11:0]   SETPT    = 12'(IMG_W / 2);
    localparam int                   LW       = $clog2(LOST_LIMIT + 1);
    localparam logic [PWM_BITS-1:0]  CNT_MAX  = '1;
    localparam logic [PWM_BITS-1:0]  DUTY_MAX = '1;
    localparam logic [PWM_BITS-1:0]  SRCH_D   = PWM_BITS'(SEARCH_DUTY);
    localparam logic signed [15:0]   BASE_W   = 16'(BASE_DUTY);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_SEARCH = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Registered copies of the tracker outputs; the law never looks at raw inputs
    logic        en_q;
    logic [10:0] x_q;
    logic        vld_q;
    logic        lost_q;

    state_t                state_q;
    logic signed [11:0]    e_prev;
    logic [LW-1:0]         lost_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;

    // Saturate a wide signed duty into the unsigned PWM range
    function automatic logic [PWM_BITS-1:0] sat_duty(input logic signed [15:0] v);
        logic [PWM_BITS-1:0] r;
        if (v[15])
            r = '0;
        else if (v[14:0] > 15'(DUTY_MAX))
            r = DUTY_MAX;
        else
            r = v[PWM_BITS-1:0];
        return r;
    endfunction

    // Capture tracker outputs and the run request every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            x_q    <= '0;
            vld_q  <= 1'b0;
            lost_q <= 1'b0;
        end else begin
            en_q   <= enable;
            x_q    <= centroid_x;
            vld_q  <= line_valid;
            lost_q <= line_lost;
        end
    end

    // A sighting needs valid and not-lost; every other flag combination is a loss
    logic sight_ok;
    assign sight_ok = vld_q & ~lost_q;

    logic                 tick;
    logic [PWM_BITS-1:0]  cnt_n;
    assign tick  = (pwm_cnt == CNT_MAX);
    assign cnt_n = pwm_cnt + 1'b1;

    logic [10:0]          x_cl;
    logic signed [11:0]   err;
    logic signed [12:0]   d_err;
    logic signed [11:0]   p_term;
    logic signed [12:0]   d_term;
    logic signed [12:0]   d_use;
    logic signed [14:0]   corr;
    logic signed [15:0]   left_raw;
    logic signed [15:0]   right_raw;
    logic [PWM_BITS-1:0]  law_l;
    logic [PWM_BITS-1:0]  law_r;
    logic [PWM_BITS-1:0]  srch_l;
    logic [PWM_BITS-1:0]  srch_r;

    // PD law: D term only contributes when already tracking (entry ticks have no valid history)
    always_comb begin
        x_cl      = (x_q > X_MAX) ? X_MAX : x_q;
        err       = $signed({1'b0, x_cl}) - SETPT;
        d_err     = $signed({err[11], err}) - $signed({e_prev[11], e_prev});
        p_term    = err >>> KP_SHIFT;
        d_term    = d_err >>> KD_SHIFT;
        d_use     = (state_q == ST_TRACK) ? d_term : 13'sd0;
        corr      = $signed({{3{p_term[11]}}, p_term}) + $signed({{2{d_use[12]}}, d_use});
        left_raw  = BASE_W + $signed({corr[14], corr});
        right_raw = BASE_W - $signed({corr[14], corr});
        law_l     = sat_duty(left_raw);
        law_r     = sat_duty(right_raw);
        srch_l    = e_prev[11] ? '0 : SRCH_D;
        srch_r    = e_prev[11] ? SRCH_D : '0;
    end

    state_t               state_n;
    logic [PWM_BITS-1:0]  duty_l_n;
    logic [PWM_BITS-1:0]  duty_r_n;
    logic signed [11:0]   e_prev_n;
    logic [LW-1:0]        lost_n;
    logic [LW-1:0]        lost_inc;

    // Next command as it would be applied at this period's tick
    always_comb begin
        state_n  = state_q;
        duty_l_n = duty_left;
        duty_r_n = duty_right;
        e_prev_n = e_prev;
        lost_n   = lost_cnt;
        lost_inc = lost_cnt + 1'b1;
        if (!en_q) begin
            state_n  = ST_IDLE;
            duty_l_n = '0;
            duty_r_n = '0;
            e_prev_n = '0;
            lost_n   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_TRACK, ST_SEARCH: begin
                    if (sight_ok) begin
                        state_n  = ST_TRACK;
                        duty_l_n = law_l;
                        duty_r_n = law_r;
                        e_prev_n = err;
                        lost_n   = '0;
                    end else if (state_q != ST_SEARCH) begin
                        state_n  = ST_SEARCH;
                        duty_l_n = srch_l;
                        duty_r_n = srch_r;
                        lost_n   = LW'(1);
                    end else if (lost_inc == LW'(LOST_LIMIT)) begin
                        state_n  = ST_STOP;
                        duty_l_n = '0;
                        duty_r_n = '0;
                        lost_n   = lost_inc;
                    end else begin
                        duty_l_n = srch_l;
                        duty_r_n = srch_r;
                        lost_n   = lost_inc;
                    end
                end
                default: begin
                    duty_l_n = '0;
                    duty_r_n = '0;
                end
            endcase
        end
    end

    // Duty that governs the next cycle: a fresh command takes over exactly at the wrap
    logic [PWM_BITS-1:0] duty_l_eff;
    logic [PWM_BITS-1:0] duty_r_eff;
    assign duty_l_eff = tick ? duty_l_n : duty_left;
    assign duty_r_eff = tick ? duty_r_n : duty_right;

    // FSM, command registers, period counter and glitch-free registered PWM outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            e_prev     <= '0;
            lost_cnt   <= '0;
            pwm_cnt    <= '0;
            duty_left  <= '0;
            duty_right <= '0;
            pwm_left   <= 1'b0;
            pwm_right  <= 1'b0;
            cmd_valid  <= 1'b0;
        end else begin
            pwm_cnt   <= cnt_n;
            cmd_valid <= tick;
            pwm_left  <= (cnt_n < duty_l_eff);
            pwm_right <= (cnt_n < duty_r_eff);
            if (tick) begin
                state_q    <= state_n;
                duty_left  <= duty_l_n;
                duty_right <= duty_r_n;
                e_prev     <= e_prev_n;
                lost_cnt   <= lost_n;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_line_steer_ctrl.sv
// Purpose: scoreboard bench for line_steer_ctrl; one directed vector per PWM period.
// Latency: each vector is driven at the start of a period and checked at the following cmd_valid pulse.
// Backpressure: n/a; the monitor pops one expectation per cmd_valid pulse.
module tb_line_steer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [10:0] centroid_x;
    logic        line_valid;
    logic        line_lost;
    logic        pwm_left;
    logic        pwm_right;
    logic [7:0]  duty_left;
    logic [7:0]  duty_right;
    logic [1:0]  state;
    logic        cmd_valid;

    line_steer_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .centroid_x (centroid_x),
        .line_valid (line_valid),
        .line_lost  (line_lost),
        .pwm_left   (pwm_left),
        .pwm_right  (pwm_right),
        .duty_left  (duty_left),
        .duty_right (duty_right),
        .state      (state),
        .cmd_valid  (cmd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit en;
        int x;
        bit v;
        bit l;
        int st;
        int dl;
        int dr;
    } vec_t;

    typedef struct {
        int idx;
        int st;
        int dl;
        int dr;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   nvec = 0;
    int   nmis = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic add(input bit en, input int x, input bit v, input bit l,
                       input int st, input int dl, input int dr);
        vec_t t;
        t.en = en; t.x = x; t.v = v; t.l = l; t.st = st; t.dl = dl; t.dr = dr;
        tbl.push_back(t);
    endtask

    // Monitor: on each cmd_valid pulse check period length, PWM high counts of the
    // period just ended, and the freshly applied command against the scoreboard.
    initial begin
        int   hi_l = 0;
        int   hi_r = 0;
        int   gap = 0;
        int   prev_l = 0;
        int   prev_r = 0;
        bit   seen = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (cmd_valid) begin
                    if (seen) check("period_len", gap, 256);
                    check("pwm_left_high_cycles", hi_l, prev_l);
                    check("pwm_right_high_cycles", hi_r, prev_r);
                    hi_l = 0; hi_r = 0; gap = 0; seen = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_cmd_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("v%0d_state", e.idx), int'(state), e.st);
                        check($sformatf("v%0d_duty_left", e.idx), int'(duty_left), e.dl);
                        check($sformatf("v%0d_duty_right", e.idx), int'(duty_right), e.dr);
                        prev_l = e.dl;
                        prev_r = e.dr;
                    end
                end
                gap++;
                hi_l += int'(pwm_left);
                hi_r += int'(pwm_right);
            end
        end
    end

    // Stimulus
    initial begin
        exp_t e;
        // idle with enable low for three periods
        add(0, 320, 1, 0, 0, 0, 0);
        add(0, 320, 1, 0, 0, 0, 0);
        add(0, 320, 1, 0, 0, 0, 0);
        // centred, then P+D step
        add(1, 320, 1, 0, 1, 128, 128);
        add(1, 400, 1, 0, 1, 158, 98);
        add(1, 400, 1, 0, 1, 148, 108);
        // loss to stop: 8th consecutive lost tick stops
        add(1, 400, 0, 1, 2, 64, 0);
        for (int i = 0; i < 6; i++) add(1, 400, 0, 1, 2, 64, 0);
        add(1, 400, 0, 1, 3, 0, 0);
        add(1, 360, 1, 0, 3, 0, 0);
        add(0, 360, 1, 0, 0, 0, 0);
        // saturation, then clamp of out-of-range centroid
        add(1, 0,   1, 0, 1, 48, 208);
        add(1, 639, 1, 0, 1, 255, 0);
        add(1, 700, 1, 0, 1, 207, 49);
        // both-flags-high and both-low count as lost
        add(1, 639, 1, 1, 2, 64, 0);
        add(1, 639, 0, 0, 2, 64, 0);
        add(1, 639, 0, 1, 2, 64, 0);
        // recovery with D forced to 0, then negative errors and floor rounding
        add(1, 360, 1, 0, 1, 138, 118);
        add(1, 200, 1, 0, 1, 78, 178);
        add(1, 317, 1, 0, 1, 141, 115);
        // spin right on negative history; full 8 ticks proves lost_cnt was cleared
        add(1, 317, 0, 1, 2, 0, 64);
        for (int i = 0; i < 6; i++) add(1, 317, 0, 1, 2, 0, 64);
        add(1, 317, 0, 1, 3, 0, 0);
        add(0, 317, 0, 1, 0, 0, 0);
        // lost straight from IDLE
        add(1, 100, 0, 1, 2, 64, 0);
        add(0, 100, 0, 1, 0, 0, 0);
        add(1, 320, 1, 0, 1, 128, 128);

        rst_n = 1'b0;
        enable = 1'b0;
        centroid_x = '0;
        line_valid = 1'b0;
        line_lost = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_duty_left", int'(duty_left), 0);
        check("rst_duty_right", int'(duty_right), 0);
        check("rst_pwm_left", int'(pwm_left), 0);
        check("rst_pwm_right", int'(pwm_right), 0);
        check("rst_cmd_valid", int'(cmd_valid), 0);

        rst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            enable     = tbl[i].en;
            centroid_x = 11'(tbl[i].x);
            line_valid = tbl[i].v;
            line_lost  = tbl[i].l;
            e.idx = i + 1; e.st = tbl[i].st; e.dl = tbl[i].dl; e.dr = tbl[i].dr;
            exp_q.push_back(e);
            repeat (256) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        // mid-period reset while both channels are high at duty 128
        repeat (8) @(negedge clk);
        mon_en = 1'b0;
        check("mid_pwm_left_before", int'(pwm_left), 1);
        check("mid_pwm_right_before", int'(pwm_right), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pwm_left", int'(pwm_left), 0);
        check("mid_rst_pwm_right", int'(pwm_right), 0);
        check("mid_rst_duty_left", int'(duty_left), 0);
        check("mid_rst_state", int'(state), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/line_steer_ctrl.md
# line_steer_ctrl

Closed-loop steering controller that consumes the ROI centroid tracker's `centroid_x` / `line_valid` / `line_lost` outputs and drives two motor PWM channels. Once per PWM period it runs a shift-gain proportional-derivative law on the horizontal error and updates a four-state track/search/stop machine. It also generates the left and right PWM waveforms. It sits between the vision pipeline and the motor driver pins.

## Interface
- `IMG_W`, 640, image width in pixels; setpoint is IMG_W/2.
- `PWM_BITS`, 8, PWM counter width; period is 2^PWM_BITS cycles.
- `KP_SHIFT`, 2, proportional gain expressed as an arithmetic right shift.
- `KD_SHIFT`, 3, derivative gain expressed as an arithmetic right shift.
- `BASE_DUTY`, 128, forward duty for both wheels at zero error.
- `SEARCH_DUTY`, 64, spin duty used in SEARCH.
- `LOST_LIMIT`, 8, number of consecutive lost ticks that forces STOP.

- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request.
- `centroid_x`  in  11  line centroid from the tracker.
- `line_valid`  in  1  centroid is meaningful.
- `line_lost`  in  1  no line pixels in the ROI.
- `pwm_left`, `pwm_right`  out  1  motor PWM outputs.
- `duty_left`, `duty_right`  out  PWM_BITS  currently applied duty values.
- `state`  out  2  current state: IDLE=0, TRACK=1, SEARCH=2, STOP=3.
- `cmd_valid`  out  1  one-cycle pulse when a new command is applied.

## Operation
- Input capture: `centroid_x`, `line_valid`, `line_lost` and `enable` are registered every cycle. The control law only uses these registered copies.
- Sighting definition: a tick counts as "valid" when `line_valid`=1 and `line_lost`=0. Any other input combination counts as "lost", including both flags high or both low.
- Clamp: before any arithmetic, a `centroid_x` value above IMG_W-1 is treated as IMG_W-1.
- Error and correction:
  - Error: e = x − IMG_W/2, 12-bit signed.
  - Difference: de = e − e_prev, 13-bit signed.
  - Correction: corr = (e >>> KP_SHIFT) + (de >>> KD_SHIFT). Shifts are arithmetic and round toward −∞.
- Duty calculation: left = BASE_DUTY + corr and right = BASE_DUTY − corr, computed at ≥15-bit signed width. Each is saturated to the range [0, 2^PWM_BITS−1].
- Control tick: one tick per period, at the cycle where `pwm_cnt` = 2^PWM_BITS−1. All state changes and duty updates happen only at ticks.
- Enable override: if `enable`=0 at a tick, from any state:
  - go to IDLE;
  - set both duties to 0;
  - clear e_prev and lost_cnt.
- IDLE (duties 0):
  - valid tick → TRACK; the D term is forced to 0 on this tick;
  - lost tick → SEARCH with lost_cnt=1.
- TRACK:
  - valid tick → apply the full law, then e_prev ← e;
  - lost tick → SEARCH with lost_cnt=1; e_prev is held.
- SEARCH (spin toward the last known side):
  - e_prev ≥ 0: left=SEARCH_DUTY, right=0;
  - e_prev < 0: left=0, right=SEARCH_DUTY;
  - valid tick → TRACK with D term forced to 0, lost_cnt ← 0, e_prev ← e;
  - lost tick → lost_cnt+1; the tick on which lost_cnt would reach LOST_LIMIT goes to STOP.
- STOP (duties 0): leaves only through the enable override to IDLE. Valid input is ignored.
- PWM generation: `pwm_cnt` is a free-running counter that wraps. In the cycle where `pwm_cnt`=k, `pwm_left` = (k < duty_left), and likewise for the right channel. Both outputs are registered and glitch-free. Duty 0 means always low; the maximum duty gives (2^PWM_BITS−1) high cycles per period.

## Timing
- Reset values: every output is 0, `state`=IDLE, `pwm_cnt`=0, e_prev=0, lost_cnt=0. Reset takes effect immediately, including mid-period.
- Input latency: an input must be stable at the clock edge at least one cycle before the tick cycle to be used by that tick. Changes between ticks have no effect.
- Command update: `duty_*` and `state` change on the clock edge that ends the tick cycle.
- `cmd_valid`: high for exactly one cycle, the cycle where `pwm_cnt`=0, every period including when in IDLE.
- Duty application: a new duty value governs the whole following period. Duty never changes mid-period.
- Command latency: input → applied duty is ≤ 2^PWM_BITS+1 cycles.

## Test plan
(All scenarios use default parameters.)
- Reset/idle: hold `rst_n`=0, then release with `enable`=0 for 3 periods → all outputs 0, `state`=0, `cmd_valid` pulses each period. Asserting `rst_n`=0 mid-period clears `pwm_*` immediately.
- Centered: `enable`=1, valid, x=320 → first tick gives TRACK with duties 128/128; `pwm_left` is high for 128 of 256 cycles.
- P+D step: after x=320, present x=400 → duties 158/98; the following period with x=400 → 148/108.
- Saturation: from IDLE with x=0 → 48/208; then x=639 → 255/0 (unsaturated values 286/−30).
- Loss to stop: in TRACK with e_prev=+80, assert lost → SEARCH with duties 64/0. On the 8th consecutive lost tick → STOP with duties 0/0. Later valid input → stays STOP. `enable`=0 → IDLE.
- Recovery: SEARCH after 3 lost ticks, then valid x=360 → TRACK with duties 138/118 (D term 0) and lost_cnt cleared.
